// File: rtl/rr_arb_pkg.sv
// Purpose : shared types and sizes for the 8-way round-robin arbiter.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
package rr_arb_pkg;

    localparam int NREQ = 8;
    localparam int IDW  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Binary requester index to one-hot grant vector.
    function automatic logic [NREQ-1:0] id2onehot(input logic [IDW-1:0] id);
        return NREQ'(1) << id;
    endfunction

endpackage

// File: rtl/rr_mask_enc.sv
// Purpose : rotated priority encoder; first set req bit at or above ptr, wrapping 7->0.
// Latency : combinational, zero cycles.
// Backpr. : none; pure function of req and ptr.
//
// Ports:
//   req [NREQ-1:0] - request vector
//   ptr [IDW-1:0]  - index that has highest priority this cycle
//   id  [IDW-1:0]  - winning index (0 when nothing requested)
//   any            - at least one request is set
module rr_mask_enc
    import rr_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  id,
    output logic            any
);

    logic [IDW-1:0] idx;

    always_comb begin
        id  = '0;
        any = 1'b0;
        idx = '0;
        // Walk the requesters starting at ptr; the IDW-bit add wraps 7->0.
        for (int i = 0; i < NREQ; i++) begin
            idx = ptr + IDW'(i);
            if (!any && req[idx]) begin
                id  = idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arb8.sv
// Purpose : 8-requester round-robin arbiter, grant held until the owner drops req.
// Latency : 1 cycle req->gnt; always one IDLE cycle between consecutive grants.
// Backpr. : en=0 blocks new grants only; an active grant is never stalled by en.
//
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   en              - allow new grants
//   req [7:0]       - level requests, held until served
//   gnt [7:0]       - registered one-hot grant
//   gnt_id [2:0]    - registered index of the grant (0 when idle)
//   gnt_valid       - grant active (equals |gnt)
//   timeout         - one-cycle pulse when a grant is forcibly revoked
//
// Optional feature macro: RR_ARB8_TIMEOUT_EN bounds each grant to HOLD_MAX
// cycles. Without it the hold counter does not exist and timeout is tied to 0.
module rr_arb8
    import rr_arb_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            gnt_valid,
    output logic            timeout
);

    if (HOLD_MAX < 1) begin : g_bad_hold_max
        $error("rr_arb8: HOLD_MAX must be at least 1");
    end

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] win_id;
    logic           win_any;
    logic           release_gnt;

    rr_mask_enc u_enc (
        .req (req),
        .ptr (ptr),
        .id  (win_id),
        .any (win_any)
    );

`ifdef RR_ARB8_TIMEOUT_EN
    localparam int CW = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;

    logic [CW-1:0] hold_cnt;
    logic          timeout_q;
    logic          hold_expired;

    // hold_cnt is 0 in the first BUSY cycle, so expiry at HOLD_MAX-1 gives
    // exactly HOLD_MAX cycles of grant.
    assign hold_expired = (hold_cnt == CW'(HOLD_MAX - 1));
    assign release_gnt  = !req[gnt_id] || hold_expired;
    assign timeout      = timeout_q;
`else
    assign release_gnt  = !req[gnt_id];
    assign timeout      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
`ifdef RR_ARB8_TIMEOUT_EN
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef RR_ARB8_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (en && win_any) begin
                        state     <= BUSY;
                        gnt       <= id2onehot(win_id);
                        gnt_id    <= win_id;
                        gnt_valid <= 1'b1;
`ifdef RR_ARB8_TIMEOUT_EN
                        hold_cnt  <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (release_gnt) begin
                        state     <= IDLE;
                        gnt       <= '0;
                        gnt_id    <= '0;
                        gnt_valid <= 1'b0;
                        // Owner drops to lowest priority for the next round.
                        ptr       <= gnt_id + IDW'(1);
`ifdef RR_ARB8_TIMEOUT_EN
                        // Only a revoke (owner still requesting) is a timeout.
                        timeout_q <= req[gnt_id];
`endif
                    end
`ifdef RR_ARB8_TIMEOUT_EN
                    else begin
                        hold_cnt <= hold_cnt + CW'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arb8.sv
// Purpose : directed self-checking bench for rr_arb8 (table vectors + corner sequences).
// Latency : checks outputs 1 ns after each rising edge.
// Backpr. : drives en/req directly; no handshake.
module tb_rr_arb8;

    localparam int HM = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int errors = 0;
    int checks = 0;

    rr_arb8 #(.HOLD_MAX(HM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [7:0] req;
        logic [7:0] g;
        logic [2:0] id;
        logic       v;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] eg, input logic [2:0] eid,
                           input logic ev, input logic eto);
        chk({tag, " gnt"}, 32'(gnt), 32'(eg));
        chk({tag, " gnt_id"}, 32'(gnt_id), 32'(eid));
        chk({tag, " gnt_valid"}, 32'(gnt_valid), 32'(ev));
        chk({tag, " timeout"}, 32'(timeout), 32'(eto));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 8'h00;
        #3;
        chk_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic void add(input logic e, input logic [7:0] r, input logic [7:0] g,
                                input logic [2:0] id, input logic v);
        vec_t t;
        t.en = e; t.req = r; t.g = g; t.id = id; t.v = v;
        tbl.push_back(t);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] toggles [10];
        logic [7:0] m;
        logic [2:0] eid;

        toggles = '{8'h21, 8'h3F, 8'hE0, 8'h24, 8'hFF, 8'h20, 8'h60, 8'hA5, 8'h30, 8'h2F};

        // Idle with en=1 and no requests.
        for (int i = 0; i < 5; i++) add(1'b1, 8'h00, 8'h00, 3'd0, 1'b0);
        // en low blocks a pending request; grant on first edge with en=1.
        add(1'b0, 8'h04, 8'h00, 3'd0, 1'b0);
        add(1'b0, 8'h04, 8'h00, 3'd0, 1'b0);
        add(1'b1, 8'h04, 8'h04, 3'd2, 1'b1);
        add(1'b0, 8'hFF, 8'h04, 3'd2, 1'b1);   // en ignored while busy
        add(1'b1, 8'h00, 8'h00, 3'd0, 1'b0);   // release, ptr=3
        add(1'b1, 8'h03, 8'h01, 3'd0, 1'b1);   // wrap-around to id 0
        add(1'b1, 8'h02, 8'h00, 3'd0, 1'b0);   // mandatory idle cycle
        add(1'b1, 8'h02, 8'h02, 3'd1, 1'b1);
        add(1'b1, 8'h00, 8'h00, 3'd0, 1'b0);   // ptr=2
        add(1'b1, 8'h20, 8'h20, 3'd5, 1'b1);
        for (int i = 0; i < 10; i++) add(1'b1, toggles[i], 8'h20, 3'd5, 1'b1);
        add(1'b1, 8'h00, 8'h00, 3'd0, 1'b0);   // ptr=6
        add(1'b1, 8'h41, 8'h40, 3'd6, 1'b1);
        add(1'b1, 8'hC1, 8'h40, 3'd6, 1'b1);
        add(1'b1, 8'h81, 8'h00, 3'd0, 1'b0);   // ptr=7
        add(1'b1, 8'h81, 8'h80, 3'd7, 1'b1);
        add(1'b1, 8'h01, 8'h00, 3'd0, 1'b0);   // ptr=0 after 7 wraps
        add(1'b1, 8'h01, 8'h01, 3'd0, 1'b1);
        add(1'b1, 8'h00, 8'h00, 3'd0, 1'b0);

        #12;
        chk_out("in_reset", 8'h00, 3'd0, 1'b0, 1'b0);
        #5;
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            en  = tbl[i].en;
            req = tbl[i].req;
            tick();
            chk_out($sformatf("vec%0d", i), tbl[i].g, tbl[i].id, tbl[i].v, 1'b0);
        end

        // Full load: order 0..7,0 with an idle cycle after each grant.
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 9; k++) begin
            eid = 3'(k % 8);
            m   = 8'h01 << eid;
            req = 8'hFF;
            tick();
            chk_out($sformatf("rr%0d", k), m, eid, 1'b1, 1'b0);
            req = 8'hFF & ~m;
            tick();
            chk_out($sformatf("rr%0d_idle", k), 8'h00, 3'd0, 1'b0, 1'b0);
        end

        // Asynchronous reset mid-grant, then id 0 has top priority.
        do_reset();
        en  = 1'b1;
        req = 8'h40;
        tick();
        chk_out("pre_rst", 8'h40, 3'd6, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        req   = 8'hC1;
        tick();
        chk_out("post_rst", 8'h01, 3'd0, 1'b1, 1'b0);

`ifdef RR_ARB8_TIMEOUT_EN
        // Held request: HM cycles of grant, timeout pulse, idle, regrant to 0.
        do_reset();
        en  = 1'b1;
        req = 8'h01;
        for (int c = 0; c < HM; c++) begin
            tick();
            chk_out($sformatf("hold%0d", c), 8'h01, 3'd0, 1'b1, 1'b0);
        end
        tick();
        chk_out("revoke", 8'h00, 3'd0, 1'b0, 1'b1);
        tick();
        chk_out("regrant", 8'h01, 3'd0, 1'b1, 1'b0);
`else
        // Without the timeout feature a held grant never ends on its own.
        do_reset();
        en  = 1'b1;
        req = 8'h01;
        for (int c = 0; c < 2 * HM + 8; c++) begin
            tick();
            chk_out($sformatf("hold%0d", c), 8'h01, 3'd0, 1'b1, 1'b0);
        end
        req = 8'h00;
        tick();
        chk_out("hold_end", 8'h00, 3'd0, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
